ct_f_spsram_param: RTL and testbench
====================================

// Module: ct_f_spsram_param
// PURPOSE
//  Parametrised FPGA single-port SRAM model with a lane write mask, for L2/cache data and tag arrays.
//  Keeps the active-low CEN/GWEN/WEN macro interface and adds:
//  - non-power-of-2 depth
//  - selectable mask granularity
//  - optional output pipeline register
//  - read-during-write mode
//  - a post-reset init sweep that fills the array with INIT_VAL
// PARAMETERS
//  DEPTH       32768  number of words; need not be a power of 2
//  ADDR_WIDTH  15     address width; must satisfy 2**ADDR_WIDTH >= DEPTH
//  DATA_WIDTH  128    word width
//  MASK_GRAN   1      bits per WEN lane; DATA_WIDTH % MASK_GRAN == 0
//  OUT_REG     0      1 adds one output pipeline stage
//  RDW_MODE    0      0 = read-first (Q returns old word on write); 1 = write-first (Q returns merged new word)
//  INIT_EN     1      1 = run the init sweep after reset
//  INIT_VAL    '0     DATA_WIDTH fill value used by the init sweep
// PORTS
//  CLK    in   1                     clock
//  RST_B  in   1                     reset, asynchronous, active-low
//  A      in   ADDR_WIDTH            address
//  CEN    in   1                     chip enable, active-low
//  GWEN   in   1                     global write enable, active-low (1 = read)
//  WEN    in   DATA_WIDTH/MASK_GRAN  lane write enable, active-low
//  D      in   DATA_WIDTH            write data
//  Q      out  DATA_WIDTH            read data
//  READY  out  1                     high = array accepts accesses; low during reset and init sweep
// BEHAVIOUR
//  - One clock (CLK); reset RST_B is asynchronous and active-low.
//  - Reset: all registered outputs clear while RST_B=0: Q=0, READY=0, FSM=INIT (INIT_EN=1) or DONE (INIT_EN=0).
//    Array contents are not reset.
//  - FSM states: INIT and DONE.
//    - INIT: a counter sweeps addresses 0..DEPTH-1, one per cycle, writing INIT_VAL with all lanes enabled.
//      External CEN/GWEN/WEN/A are ignored; Q holds 0.
//    - INIT -> DONE on the cycle the counter reaches DEPTH-1. READY rises the next cycle.
//    - Sweep takes exactly DEPTH cycles after RST_B deasserts.
//    - INIT_EN=0: READY=1 on the first CLK edge after RST_B deasserts.
//  - Access rules with READY=1, sampled on the CLK rising edge:
//    - CEN=1: no access; Q and the RAM address are held.
//    - CEN=0, GWEN=1: read.
//    - CEN=0, GWEN=0: write, lane k written iff WEN[k]=0. GWEN=0 with all WEN=1 is a write of nothing and still a
//      read-for-Q.
//  - Read latency: access at edge t -> Q valid after edge t+1 (OUT_REG=0) or t+2 (OUT_REG=1).
//  - Q holds its value until the next access completes.
//  - On a write, Q returns per RDW_MODE:
//    - RDW_MODE=0: old word.
//    - RDW_MODE=1: old word with the written lanes replaced by D.
//  - Address A >= DEPTH: the write is dropped, the read returns all-zero, and no error is flagged.
//  - Back-to-back accesses: one per cycle with no bubbles; same-address write then read returns the new data.
//  - Reset mid-sweep: the counter restarts from 0 after RST_B deasserts; partially filled contents are don't-care.
//  - Reset mid-access: the in-flight read is discarded. The pipeline register clears to 0.
//  - Accesses with READY=0 are ignored (no write, Q unchanged); the master must wait for READY.
// STRUCTURE
//  - Package ct_f_sram_pkg:
//    - typedef enum logic {INIT, DONE} sram_init_state_e;
//    - localparams RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
//    - function lane_mask(WEN) expanding WEN to a DATA_WIDTH bit mask.
//  - Sub-module ct_f_spsram_init_ctrl: init FSM, address counter and mux of init vs external A/D/write enable.
//  - Storage uses the existing fpga_ram primitive, one instance per mask lane
//    (DATAWIDTH=MASK_GRAN, ADDRWIDTH=ADDR_WIDTH).
//  - Out-of-range gating, RDW merge and the optional OUT_REG stage stay in the top module.
// TESTING
//  1. Init sweep: DEPTH=100, INIT_VAL=0xA5.., INIT_EN=1; release reset ->
//     READY=0 for 100 cycles then 1; reads of addresses 0, 57 and 99 return 0xA5...
//  2. Lane mask: MASK_GRAN=8; write D=all-ones, WEN=0xFFFE to addr 3; read addr 3 -> only byte 0 = 0xFF,
//     other bytes equal INIT_VAL.
//  3. Latency and hold: OUT_REG=1; read at edge t -> Q valid after edge t+2; CEN=1 for 5 cycles -> Q unchanged.
//  4. RDW: old word 0x1111, write 0x2222 to the same address.
//     - RDW_MODE=0: Q=0x1111.
//     - RDW_MODE=1: Q=0x2222.
//     - Next-cycle read returns 0x2222 in both modes.
//  5. Out-of-range: DEPTH=100; write address 120 then read it -> Q=0; address 120 mod 128 aliasing untouched.
//  6. Reset mid-sweep: assert RST_B=0 at sweep index 40 -> Q=0 and READY=0 immediately; release ->
//     full DEPTH-cycle sweep, READY rises on the correct cycle.

Source files
------------

// File: rtl/ct_f_sram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM model.
// - sram_init_state_e : init sweep FSM states
// - RDW_*             : read-during-write mode encodings
// - lane_mask()       : expands an active-low lane write enable into an
//                       active-high per-bit write mask
package ct_f_sram_pkg;

  typedef enum logic {INIT, DONE} sram_init_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word lane_mask() handles; DATA_WIDTH must not exceed it.
  localparam int SRAM_MAX_DW = 1024;
  localparam int SRAM_MAX_IW = $clog2(SRAM_MAX_DW);

  // Bit b of the result is set when lane b/gran is enabled (wen_n low).
  // Bits at and above width stay 0.
  function automatic logic [SRAM_MAX_DW-1:0] lane_mask(
    input logic [SRAM_MAX_DW-1:0] wen_n,
    input int                     gran,
    input int                     width
  );
    logic [SRAM_MAX_DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < width; b++) begin
      mask[SRAM_MAX_IW'(b)] = ~wen_n[SRAM_MAX_IW'(b / gran)];
    end
    return mask;
  endfunction

endpackage

// File: rtl/ct_f_spsram_init_ctrl.sv
// Post-reset init sweep controller and RAM port multiplexer.
// While in INIT it drives every address 0..DEPTH-1 once with init_val on all
// lanes and holds ready low; in DONE it passes the external request through,
// gated by ready.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   ext_en                 - external access request (active-high)
//   ext_addr/ext_din       - external address / write data
//   ext_we                 - external per-lane write enable (active-high)
//   ram_en/ram_addr/ram_din/ram_we - muxed RAM port
//   ready                  - registered; high once the array accepts accesses
module ct_f_spsram_init_ctrl
  import ct_f_sram_pkg::*;
#(
  parameter int                  DEPTH      = 32768,
  parameter int                  ADDR_WIDTH = 15,
  parameter int                  DATA_WIDTH = 128,
  parameter int                  LANES      = 128,
  parameter int                  INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_en,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_din,
  input  logic [LANES-1:0]      ext_we,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [LANES-1:0]      ram_we,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam sram_init_state_e RESET_STATE = (INIT_EN != 0) ? INIT : DONE;

  sram_init_state_e      state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  in_init;
  logic                  ext_acc;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        // Last sweep write happens on this edge; ready rises with it.
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      DONE: ready_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign in_init  = (state_q == INIT);
  assign ext_acc  = ready_q & ext_en;
  assign ram_en   = in_init | ext_acc;
  assign ram_addr = in_init ? cnt_q : ext_addr;
  assign ram_din  = in_init ? INIT_VAL : ext_din;
  assign ram_we   = in_init ? {LANES{1'b1}} : (ext_acc ? ext_we : '0);
  assign ready    = ready_q;

endmodule

// File: rtl/fpga_ram.sv
// Generic FPGA block-RAM primitive: single port, registered read-first output.
// Ports:
//   clk  - clock
//   en   - port enable; when low the address is ignored and dout holds
//   we   - write enable (active-high)
//   addr - word address
//   din  - write data
//   dout - read data, valid after the edge that sampled addr (old word on write)
module fpga_ram #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout
);

  logic [DATAWIDTH-1:0] mem [0:(1<<ADDRWIDTH)-1];

  // NOTE: storage arrays get no reset; a reset port here would stop block-RAM
  // inference and turn the array into flops. Contents are defined by writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM with active-low CEN/GWEN/WEN macro interface,
// per-lane write mask, non-power-of-2 depth, optional output register,
// selectable read-during-write behaviour and a post-reset init sweep.
// Ports:
//   CLK, RST_B - clock, asynchronous active-low reset
//   A          - address; A >= DEPTH drops writes and reads back zero
//   CEN        - chip enable (active-low)
//   GWEN       - global write enable (active-low, 1 = read)
//   WEN        - lane write enable (active-low), one bit per MASK_GRAN bits
//   D          - write data
//   Q          - read data, held until the next access completes
//   READY      - high once the init sweep is done
module ct_f_spsram_param
  import ct_f_sram_pkg::*;
#(
  parameter int                    DEPTH      = 32768,
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    MASK_GRAN  = 1,
  parameter int                    OUT_REG    = 0,
  parameter int                    RDW_MODE   = 0,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                              CLK,
  input  logic                              RST_B,
  input  logic [ADDR_WIDTH-1:0]             A,
  input  logic                              CEN,
  input  logic                              GWEN,
  input  logic [DATA_WIDTH/MASK_GRAN-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0]             D,
  output logic [DATA_WIDTH-1:0]             Q,
  output logic                              READY
);

  localparam int LANES = DATA_WIDTH / MASK_GRAN;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic                  in_range;
  logic                  acc;
  logic [LANES-1:0]      ext_we;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [LANES-1:0]      ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign in_range = ({1'b0, A} < DEPTH_W);
  assign acc      = READY & ~CEN;
  // Out-of-range writes are dropped by clearing every lane enable.
  assign ext_we   = ~WEN & {LANES{~GWEN & in_range}};
  // Bit mask of written bits, used only for the write-first merge.
  assign wr_mask  = DATA_WIDTH'(lane_mask(SRAM_MAX_DW'(WEN), MASK_GRAN, DATA_WIDTH))
                  & {DATA_WIDTH{~GWEN}};

  ct_f_spsram_init_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .INIT_EN    (INIT_EN),
    .INIT_VAL   (INIT_VAL)
  ) u_init_ctrl (
    .clk      (CLK),
    .rst_n    (RST_B),
    .ext_en   (~CEN),
    .ext_addr (A),
    .ext_din  (D),
    .ext_we   (ext_we),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ready    (READY)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fpga_ram #(
      .DATAWIDTH (MASK_GRAN),
      .ADDRWIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk  (CLK),
      .en   (ram_en),
      .we   (ram_we[k]),
      .addr (ram_addr),
      .din  (ram_din[k*MASK_GRAN +: MASK_GRAN]),
      .dout (ram_dout[k*MASK_GRAN +: MASK_GRAN])
    );
  end

  // Stage 1 tracks the access the RAM is serving; stage 2 (data_q) is the
  // first point where Q can be reset, so the base latency is two edges.
  logic                  rd_vld_q, rd_vld_d;
  logic                  oor_q, oor_d;
  logic [DATA_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    rd_vld_d = acc;
    oor_d    = oor_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    if (acc) begin
      oor_d   = ~in_range;
      wmask_d = wr_mask;
      wdata_d = D;
    end
    merged = (RDW_MODE == RDW_WRITE_FIRST)
           ? ((ram_dout & ~wmask_q) | (wdata_q & wmask_q))
           : ram_dout;
    data_d = data_q;
    if (rd_vld_q) begin
      data_d = oor_q ? '0 : merged;
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      rd_vld_q <= 1'b0;
      oor_q    <= 1'b0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      oor_q    <= oor_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  data_vld_q;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb begin
      out_d = data_vld_q ? data_q : out_q;
    end

    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        data_vld_q <= 1'b0;
        out_q      <= '0;
      end else begin
        data_vld_q <= rd_vld_q;
        out_q      <= out_d;
      end
    end

    assign Q = out_q;
  end else begin : g_no_out_reg
    assign Q = data_q;
  end

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param. Two instances share one stimulus stream:
//   dut0: OUT_REG=0, RDW_MODE=0 (read-first)
//   dut1: OUT_REG=1, RDW_MODE=1 (write-first)
// Both: DEPTH=100, ADDR_WIDTH=7, DATA_WIDTH=32, MASK_GRAN=8, INIT_VAL=A5A5A5A5.
// Stimulus pushes expected values with the cycle they are due; a monitor
// pops and compares on the falling edge.
module tb_ct_f_spsram_param;

  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int G     = 8;
  localparam int LN    = DW / G;
  localparam logic [DW-1:0] IV = 32'hA5A5A5A5;

  logic          CLK   = 1'b0;
  logic          RST_B = 1'b0;
  logic [AW-1:0] A     = '0;
  logic          CEN   = 1'b1;
  logic          GWEN  = 1'b1;
  logic [LN-1:0] WEN   = '1;
  logic [DW-1:0] D     = '0;
  logic [DW-1:0] q0, q1;
  logic          rdy0, rdy1;

  ct_f_spsram_param #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_GRAN(G),
    .OUT_REG(0), .RDW_MODE(0), .INIT_EN(1), .INIT_VAL(IV)
  ) dut0 (
    .CLK(CLK), .RST_B(RST_B), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(q0), .READY(rdy0)
  );

  ct_f_spsram_param #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_GRAN(G),
    .OUT_REG(1), .RDW_MODE(1), .INIT_EN(1), .INIT_VAL(IV)
  ) dut1 (
    .CLK(CLK), .RST_B(RST_B), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(q1), .READY(rdy1)
  );

  always #5 CLK = ~CLK;

  // Number of rising edges so far; stable when read on the falling edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          which;   // 0: dut0 Q, 1: dut1 Q, 2: dut0 READY, 3: dut1 READY
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_t  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int due, input int which, input logic [31:0] exp, input string name);
    sb.push_back('{due, which, exp, name});
  endtask

  function automatic logic [31:0] sel(input int which);
    case (which)
      0:       return q0;
      1:       return q1;
      2:       return {31'b0, rdy0};
      default: return {31'b0, rdy1};
    endcase
  endfunction

  // Monitor: compare every entry that has come due.
  initial begin
    forever begin
      @(negedge CLK);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          check($sformatf("%s/%0d", sb[i].name, sb[i].which), sel(sb[i].which), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  task automatic drive(input logic [AW-1:0] a, input logic cen, input logic gwen,
                       input logic [LN-1:0] wen, input logic [DW-1:0] d);
    @(negedge CLK);
    A = a; CEN = cen; GWEN = gwen; WEN = wen; D = d;
  endtask

  // One access sampled on edge t = last_t; dut0 Q due after t+1, dut1 after t+2.
  task automatic acc(input logic [AW-1:0] a, input logic gwen, input logic [LN-1:0] wen,
                     input logic [DW-1:0] d, input logic [DW-1:0] e0,
                     input logic [DW-1:0] e1, input string name);
    drive(a, 1'b0, gwen, wen, d);
    last_t = cyc + 1;
    push(last_t + 1, 0, e0, name);
    push(last_t + 2, 1, e1, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(AW'($urandom), 1'b1, 1'b0, '0, $urandom);
  endtask

  task automatic expect_ready(input int base, input string name);
    push(base + 1,   2, 0, {name, "_rdy1"});
    push(base + 1,   3, 0, {name, "_rdy1"});
    push(base + 99,  2, 0, {name, "_rdy99"});
    push(base + 99,  3, 0, {name, "_rdy99"});
    push(base + 100, 2, 1, {name, "_rdy100"});
    push(base + 100, 3, 1, {name, "_rdy100"});
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    // Reset state.
    repeat (3) @(negedge CLK);
    for (int w = 0; w < 4; w++) push(cyc + 1, w, 0, "reset");
    @(negedge CLK);

    // 1. Init sweep: READY low for DEPTH edges, then high.
    @(negedge CLK);
    RST_B = 1'b1;
    r = cyc;
    expect_ready(r, "sweep");
    push(r + 50, 0, 0, "sweep_q");
    wait_until(r + 100);
    acc(0,  1'b1, '1, '0, IV, IV, "init_rd0");
    acc(57, 1'b1, '1, '0, IV, IV, "init_rd57");
    acc(99, 1'b1, '1, '0, IV, IV, "init_rd99");

    // 2. Lane mask: byte 0 only.
    acc(3, 1'b0, 4'b1110, 32'hFFFFFFFF, IV, 32'hA5A5A5FF, "lane_wr");
    acc(3, 1'b1, '1, '0, 32'hA5A5A5FF, 32'hA5A5A5FF, "lane_rd");

    // 4. Read-during-write.
    acc(10, 1'b0, '0, 32'h00001111, IV, 32'h00001111, "rdw_wr1");
    acc(10, 1'b0, '0, 32'h00002222, 32'h00001111, 32'h00002222, "rdw_wr2");
    acc(10, 1'b1, '1, '0, 32'h00002222, 32'h00002222, "rdw_rd");

    // 3. Latency and hold with CEN high and junk on the other inputs.
    acc(3, 1'b1, '1, '0, 32'hA5A5A5FF, 32'hA5A5A5FF, "lat_rd");
    push(last_t + 1, 1, 32'h00002222, "lat_dut1_old");
    for (int i = 1; i <= 5; i++) begin
      push(last_t + 1 + i, 0, 32'hA5A5A5FF, "hold");
      push(last_t + 2 + i, 1, 32'hA5A5A5FF, "hold");
    end
    idle(5);

    // 5. Out-of-range: write dropped, read zero, aliases untouched.
    acc(120, 1'b0, '0, 32'hDEADBEEF, 0, 0, "oor_wr");
    acc(120, 1'b1, '1, '0, 0, 0, "oor_rd");
    acc(56,  1'b1, '1, '0, IV, IV, "alias56");
    acc(20,  1'b1, '1, '0, IV, IV, "alias20");
    idle(2);

    // 6a. Reset mid-access: Q and READY clear at once, in-flight read dropped.
    drive(57, 1'b0, 1'b1, '1, '0);
    @(posedge CLK);
    #2;
    RST_B = 1'b0;
    for (int w = 0; w < 4; w++) push(cyc, w, 0, "rst_async");
    drive(0, 1'b1, 1'b1, '1, '0);
    @(negedge CLK);
    RST_B = 1'b1;
    r = cyc;

    // 6b. Reset again at sweep index 40.
    wait_until(r + 40);
    RST_B = 1'b0;
    push(cyc + 1, 2, 0, "rst_mid");
    push(cyc + 1, 0, 0, "rst_mid_q");
    repeat (2) @(negedge CLK);
    RST_B = 1'b1;
    r = cyc;
    expect_ready(r, "resweep");
    push(r + 50, 0, 0, "resweep_q");
    // Write attempt while READY is low must be ignored.
    wait_until(r + 30);
    A = 5; CEN = 1'b0; GWEN = 1'b0; WEN = '0; D = 32'h12345678;
    @(negedge CLK);
    CEN = 1'b1;
    wait_until(r + 100);
    acc(5,  1'b1, '1, '0, IV, IV, "reinit5");
    acc(3,  1'b1, '1, '0, IV, IV, "reinit3");
    acc(99, 1'b1, '1, '0, IV, IV, "reinit99");
    idle(1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/%0d: never compared, expected %h", sb[i].name, sb[i].which, sb[i].exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
